// File: rtl/sampled_value_detect.sv
// Multi-channel sampled-value evaluator: compares each channel with its value
// PAST_DEPTH samples earlier (rose/fell/stable/changed) and counts hit cycles.
module sampled_value_detect #(
  parameter int WIDTH      = 8,
  parameter int PAST_DEPTH = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       func,
  input  logic [WIDTH-1:0] signal_in,
  input  logic             clr,
  output logic             valid,
  output logic [WIDTH-1:0] match,
  output logic [WIDTH-1:0] fail,
  output logic             match_any,
  output logic [CNT_W-1:0] hits
);

  localparam int WC_W = $clog2(PAST_DEPTH + 2);
  localparam logic [WC_W-1:0] WC_FULL = WC_W'(PAST_DEPTH + 1);

  logic [WIDTH-1:0] hist_reg [0:PAST_DEPTH];
  logic             en_q_reg;
  logic [1:0]       func_q_reg;
  logic [WC_W-1:0]  wcnt_reg;
  logic [CNT_W-1:0] hits_reg;
  logic [WIDTH-1:0] f_vec;
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] past;

  // en/func travel with the sample so a mode change applies to that very sample
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist_reg[0] <= '0;
      en_q_reg    <= 1'b0;
      func_q_reg  <= 2'b00;
    end else begin
      hist_reg[0] <= signal_in;
      en_q_reg    <= en;
      func_q_reg  <= func;
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi <= PAST_DEPTH; gi++) begin : g_hist
      always_ff @(posedge clk) begin
        if (!rst_n) hist_reg[gi] <= '0;
        else        hist_reg[gi] <= hist_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n)                  wcnt_reg <= '0;
    else if (wcnt_reg != WC_FULL) wcnt_reg <= wcnt_reg + WC_W'(1);
  end

  assign valid = (wcnt_reg == WC_FULL);
  assign cur   = hist_reg[0];
  assign past  = hist_reg[PAST_DEPTH];

  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_chan
      always_comb begin
        f_vec[gi] = 1'b0;
        case (func_q_reg)
          2'b00:   f_vec[gi] = ~past[gi] &  cur[gi];
          2'b01:   f_vec[gi] =  past[gi] & ~cur[gi];
          2'b10:   f_vec[gi] = ~(past[gi] ^ cur[gi]);
          default: f_vec[gi] =  past[gi] ^ cur[gi];
        endcase
      end
      assign match[gi] =  f_vec[gi] & en_q_reg & valid;
      assign fail[gi]  = ~f_vec[gi] & en_q_reg & valid;
    end
  endgenerate

  assign match_any = |match;

  // clear beats a simultaneous hit; counter parks at all-ones
  always_ff @(posedge clk) begin
    if (!rst_n)
      hits_reg <= '0;
    else if (clr)
      hits_reg <= '0;
    else if (match_any && (hits_reg != {CNT_W{1'b1}}))
      hits_reg <= hits_reg + CNT_W'(1);
  end

  assign hits = hits_reg;

endmodule

// File: tb/tb_sampled_value_detect.sv
// Randomized and directed bench for sampled_value_detect against a
// sample-queue reference model.
module tb_sampled_value_detect;

  localparam int W  = 4;
  localparam int PD = 2;
  localparam int CW = 4;
  localparam int HMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [1:0]    func = 2'b00;
  logic [W-1:0]  signal_in = '0;
  logic          clr = 1'b0;
  logic          valid;
  logic [W-1:0]  match;
  logic [W-1:0]  fail;
  logic          match_any;
  logic [CW-1:0] hits;

  int total = 0;
  int bad = 0;
  int nstep = 0;

  // reference model state: samples seen since reset, plus their en/func
  logic [W-1:0] smp[$];
  bit           m_en;
  logic [1:0]   m_func;
  int           m_hits;

  sampled_value_detect #(.WIDTH(W), .PAST_DEPTH(PD), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .func(func), .signal_in(signal_in),
    .clr(clr), .valid(valid), .match(match), .fail(fail),
    .match_any(match_any), .hits(hits)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%0h want=%0h", tag, nstep, got, exp);
    end
  endtask

  function automatic bit model_valid();
    return smp.size() == PD + 1;
  endfunction

  function automatic logic [W-1:0] model_match(input bit want_true);
    logic [W-1:0] r;
    logic [W-1:0] c;
    logic [W-1:0] p;
    bit f;
    r = '0;
    if (model_valid() && m_en) begin
      c = smp[PD];
      p = smp[0];
      for (int i = 0; i < W; i++) begin
        case (m_func)
          2'd0:    f = (p[i] == 1'b0) && (c[i] == 1'b1);
          2'd1:    f = (p[i] == 1'b1) && (c[i] == 1'b0);
          2'd2:    f = (p[i] == c[i]);
          default: f = (p[i] != c[i]);
        endcase
        r[i] = (f == want_true);
      end
    end
    return r;
  endfunction

  task automatic step(input logic rn, input logic e, input logic [1:0] fn,
                      input logic [W-1:0] s, input logic c);
    bit any_before;
    logic [W-1:0] em;
    logic [W-1:0] ef;
    @(negedge clk);
    rst_n = rn; en = e; func = fn; signal_in = s; clr = c;
    any_before = (model_match(1'b1) != '0);
    @(posedge clk);
    if (!rn) begin
      smp.delete();
      m_en = 1'b0; m_func = 2'b00; m_hits = 0;
    end else begin
      if (c) m_hits = 0;
      else if (any_before && m_hits < HMAX) m_hits++;
      smp.push_back(s);
      if (smp.size() > PD + 1) void'(smp.pop_front());
      m_en = e; m_func = fn;
    end
    #1;
    nstep++;
    em = model_match(1'b1);
    ef = model_match(1'b0);
    check("valid", 64'(valid), 64'(model_valid()));
    check("match", 64'(match), 64'(em));
    check("fail", 64'(fail), 64'(ef));
    check("match_any", 64'(match_any), 64'(em != '0));
    check("hits", 64'(hits), 64'(m_hits));
    $display("step %0d rst_n=%b en=%b func=%0d sig=%b clr=%b -> valid=%b match=%b fail=%b hits=%0d",
             nstep, rn, e, fn, s, c, valid, match, fail, hits);
  endtask

  initial begin
    m_en = 1'b0; m_func = 2'b00; m_hits = 0;

    // reset and changed/fell with a mode switch on a sample boundary
    step(0, 0, 2'd0, 4'b0000, 0);
    step(0, 0, 2'd0, 4'b0000, 0);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_hits", 64'(hits), 64'd0);
    step(1, 1, 2'd3, 4'b0011, 0);
    step(1, 1, 2'd3, 4'b0011, 0);
    check("warm_valid", 64'(valid), 64'd0);
    step(1, 1, 2'd3, 4'b1010, 0);
    check("chg_match", 64'(match), 64'b1001);
    check("chg_fail", 64'(fail), 64'b0110);
    step(1, 1, 2'd1, 4'b0000, 0);
    check("fell_match", 64'(match), 64'b0011);

    // enable gating with rose
    step(1, 0, 2'd0, 4'b0000, 0);
    step(1, 0, 2'd0, 4'b0000, 0);
    step(1, 0, 2'd0, 4'b1111, 0);
    check("gate_match", 64'(match), 64'd0);
    check("gate_fail", 64'(fail), 64'd0);
    step(1, 1, 2'd0, 4'b0000, 0);
    step(1, 1, 2'd0, 4'b0000, 0);
    step(1, 1, 2'd0, 4'b1111, 0);
    check("rose_match", 64'(match), 64'b1111);

    // saturation and clear-over-increment
    step(0, 0, 2'd0, 4'b0000, 0);
    for (int k = 0; k < 20; k++) step(1, 1, 2'd2, 4'b0101, 0);
    check("sat_hits", 64'(hits), 64'(HMAX));
    step(1, 1, 2'd2, 4'b0101, 1);
    check("clr_hits", 64'(hits), 64'd0);
    for (int k = 0; k < 7; k++) step(1, 1, 2'd2, 4'b0101, 0);
    check("pre_rst_hits", 64'(hits), 64'd7);

    // mid-operation reset, then rise on the first post-reset sample
    step(0, 1, 2'd0, 4'b0000, 0);
    check("mid_rst_valid", 64'(valid), 64'd0);
    check("mid_rst_hits", 64'(hits), 64'd0);
    step(1, 1, 2'd0, 4'b1111, 0);
    check("post_rst_match", 64'(match), 64'd0);
    step(1, 1, 2'd0, 4'b1111, 0);
    check("post_rst_valid", 64'(valid), 64'd0);
    step(1, 1, 2'd0, 4'b1111, 0);
    check("post_rst_valid2", 64'(valid), 64'd1);

    // randomized traffic
    for (int k = 0; k < 300; k++) begin
      step(($urandom_range(0, 39) != 0), $urandom_range(0, 3) != 0,
           2'($urandom_range(0, 3)), 4'($urandom), $urandom_range(0, 15) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
